// File: rtl/PARAMS_pkg.sv
// PARAMS_pkg: shared widths, reset PC and the fetch queue entry type
package PARAMS_pkg;
  localparam int ADDR_SIZE = 32;
  localparam int INSTR_SIZE = 32;
  localparam logic [ADDR_SIZE-1:0] RESET_PC = 32'h0000_1000;
  typedef struct packed {
    logic [ADDR_SIZE-1:0]  pc;
    logic [INSTR_SIZE-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch entries with flush
// Ports: clk/reset; push_i/data_i write, pop_i read (head on data_o),
//   flush_i empties the FIFO and overrides push/pop; count_o/full_o/empty_o status.
module fetch_queue
  import PARAMS_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           data_i,
  output fetch_entry_t           data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic do_push, do_pop;
  assign do_push = push_i && !flush_i;
  assign do_pop = pop_i && !flush_i && !empty_o;
  assign data_o = mem_q[rd_q];
  assign count_o = count_q;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + AW'(1) : wr_q;
      rd_q <= do_pop ? rd_q + AW'(1) : rd_q;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= data_i;
  // The upstream credit scheme must never let a push land on a full FIFO.
  assert property (@(posedge clk) disable iff (reset) !(do_push && full_o));
endmodule

// File: rtl/stage_fetch.sv
// stage_fetch: instruction fetch stage feeding decode
// Ports: clk/reset (async, active-high); imem_req_valid_o/ready_i/addr_o request
//   channel; imem_rsp_valid_i/data_i in-order responses; redirect_i/redirect_pc_i
//   restart fetch; stall_i decode backpressure; instr_valid_o/instr_o/pc_o to decode.
module stage_fetch
  import PARAMS_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [ADDR_SIZE-1:0]  imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [INSTR_SIZE-1:0] imem_rsp_data_i,
  input  logic                  redirect_i,
  input  logic [ADDR_SIZE-1:0]  redirect_pc_i,
  input  logic                  stall_i,
  output logic                  instr_valid_o,
  output logic [INSTR_SIZE-1:0] instr_o,
  output logic [ADDR_SIZE-1:0]  pc_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, q_cnt, tag_cnt;
  logic credit, hs, rsp_keep, q_full, q_empty, tag_full, tag_empty;
  fetch_entry_t q_in, q_head, tag_in, tag_head;
  logic unused_bits;
  // Credit counts both in-flight requests and buffered entries, so every
  // response is guaranteed a free queue slot.
  assign credit = ({1'b0, out_q} + {1'b0, q_cnt}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid_o = !reset && !redirect_i && credit;
  assign imem_req_addr_o = reset ? '0 : pc_q;
  assign hs = imem_req_valid_o && imem_req_ready_i;
  // Responses to requests issued before a redirect are counted in drop_q.
  assign rsp_keep = imem_rsp_valid_i && drop_q == '0 && !redirect_i;
  assign instr_valid_o = !q_empty;
  assign instr_o = instr_valid_o ? q_head.instr : '0;
  assign pc_o = instr_valid_o ? q_head.pc : '0;
  assign q_in = '{pc: tag_head.pc, instr: imem_rsp_data_i};
  assign tag_in = '{pc: pc_q, instr: '0};
  assign unused_bits = ^{redirect_pc_i[1:0], tag_head.instr, tag_cnt, tag_full, tag_empty, q_full};
  always_comb begin
    pc_d = redirect_i ? {redirect_pc_i[ADDR_SIZE-1:2], 2'b00} : hs ? pc_q + ADDR_SIZE'(4) : pc_q;
    out_d = out_q + CW'(hs) - CW'(imem_rsp_valid_i);
    drop_d = redirect_i ? out_q - CW'(imem_rsp_valid_i)
           : (imem_rsp_valid_i && drop_q != '0) ? drop_q - CW'(1) : drop_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  fetch_queue #(.DEPTH(FIFO_DEPTH)) u_instr_q (
    .clk(clk), .reset(reset), .push_i(rsp_keep), .pop_i(instr_valid_o && !stall_i),
    .flush_i(redirect_i), .data_i(q_in), .data_o(q_head), .count_o(q_cnt),
    .full_o(q_full), .empty_o(q_empty)
  );
  // PC tags of live requests, in issue order; the instr field is not used.
  fetch_queue #(.DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk(clk), .reset(reset), .push_i(hs), .pop_i(rsp_keep),
    .flush_i(redirect_i), .data_i(tag_in), .data_o(tag_head), .count_o(tag_cnt),
    .full_o(tag_full), .empty_o(tag_empty)
  );
endmodule

// File: tb/tb_stage_fetch.sv
module tb_stage_fetch;
  localparam int D = 2;
  logic clk = 0, reset = 1;
  logic imem_req_valid_o, imem_req_ready_i = 0, imem_rsp_valid_i = 0;
  logic [31:0] imem_req_addr_o, imem_rsp_data_i = 0, redirect_pc_i = 0, instr_o, pc_o;
  logic redirect_i = 0, stall_i = 0, instr_valid_o;

  stage_fetch #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o), .imem_rsp_valid_i(imem_rsp_valid_i),
    .imem_rsp_data_i(imem_rsp_data_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  // Model: every accepted request in issue order (dropped once a redirect
  // overtakes it), plus the list of instructions waiting for decode.
  typedef struct {logic [31:0] pc; bit drop; int due;} fl_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  fl_t fl[$];
  ent_t mq[$];
  logic [31:0] m_pc = 32'h1000;
  int cyc = 0, last_due = 0, vec = 0, miss = 0;
  bit obs_rv, obs_iv;
  logic [31:0] obs_addr, obs_pc;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // One clock cycle: drive inputs, compare at negedge, advance the model.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc, input bit stl, input int lat);
    bit rv, ev;
    int d;
    fl_t f;
    rv = fl.size() > 0 && fl[0].due <= cyc;
    imem_req_ready_i = rdy;
    imem_rsp_valid_i = rv;
    imem_rsp_data_i = rv ? instr_of(fl[0].pc) : $urandom;
    redirect_i = redir;
    redirect_pc_i = rpc;
    stall_i = stl;
    @(negedge clk);
    ev = !redir && (fl.size() + mq.size() < D);
    obs_rv = imem_req_valid_o;
    obs_addr = imem_req_addr_o;
    obs_iv = instr_valid_o;
    obs_pc = pc_o;
    chk("req_valid", {31'b0, imem_req_valid_o}, {31'b0, ev});
    if (ev) chk("req_addr", imem_req_addr_o, m_pc);
    chk("instr_valid", {31'b0, instr_valid_o}, mq.size() > 0 ? 1 : 0);
    if (mq.size() > 0) begin
      chk("pc_o", pc_o, mq[0].pc);
      chk("instr_o", instr_o, mq[0].instr);
    end
    if (redir) begin
      if (rv) f = fl.pop_front();
      foreach (fl[i]) fl[i].drop = 1;
      mq.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (mq.size() > 0 && !stl) void'(mq.pop_front());
      if (rv) begin
        f = fl.pop_front();
        if (!f.drop) mq.push_back('{pc: f.pc, instr: instr_of(f.pc)});
      end
      if (ev && rdy) begin
        d = cyc + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        fl.push_back('{pc: m_pc, drop: 1'b0, due: d});
        m_pc += 4;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Reset asserted between clock edges; outputs must drop with no edge.
  task automatic do_reset();
    #2 reset = 1;
    #1;
    chk("rst_instr_valid", {31'b0, instr_valid_o}, 0);
    chk("rst_req_valid", {31'b0, imem_req_valid_o}, 0);
    chk("rst_req_addr", imem_req_addr_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_pc", pc_o, 0);
    imem_req_ready_i = 1;
    imem_rsp_valid_i = 0;
    redirect_i = 0;
    stall_i = 0;
    fl.delete();
    mq.delete();
    m_pc = 32'h1000;
    last_due = cyc;
    @(posedge clk);
    cyc++;
    #1 chk("rst_req_valid_edge", {31'b0, imem_req_valid_o}, 0);
    @(posedge clk);
    cyc++;
    #1 reset = 0;
  endtask

  task automatic t1_stream();
    logic [31:0] got[$];
    int first = -1;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 1);
      if (i == 0) chk("t1_addr0", obs_addr, 32'h1000);
      if (obs_iv) begin
        if (first < 0) first = i;
        got.push_back(obs_pc);
      end
    end
    chk("t1_first_valid_cycle", first, 2);
    for (int i = 0; i < 4; i++)
      chk("t1_order", i < got.size() ? got[i] : 32'hx, 32'h1000 + 32'(4 * i));
  endtask

  task automatic t2_stall();
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, 1);
      if (i >= 2) chk("t2_no_req", {31'b0, obs_rv}, 0);
    end
    chk("t2_held_valid", {31'b0, obs_iv}, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1);
  endtask

  task automatic t3_ready_low();
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 1);
      chk("t3_hold_valid", {31'b0, obs_rv}, 1);
      chk("t3_hold_addr", obs_addr, 32'h1008);
    end
    step(1, 0, 0, 0, 1);
    chk("t3_issue_addr", obs_addr, 32'h1008);
    step(1, 0, 0, 0, 1);
    chk("t3_next_addr", obs_addr, 32'h100c);
  endtask

  task automatic t4_redirect_inflight();
    bit found = 0;
    do_reset();
    step(1, 0, 0, 0, 3);
    step(1, 0, 0, 0, 3);
    chk("t4_inflight", fl.size(), 2);
    step(1, 1, 32'h2000, 0, 1);
    chk("t4_no_req_on_redirect", {31'b0, obs_rv}, 0);
    for (int i = 0; i < 30 && !found; i++) begin
      step(1, 0, 0, 0, 1);
      if (obs_iv) begin
        found = 1;
        chk("t4_first_pc", obs_pc, 32'h2000);
      end
    end
    if (!found) chk("t4_timeout", 0, 1);
  endtask

  task automatic t5_redirect_with_rsp();
    do_reset();
    step(1, 0, 0, 0, 1);
    step(1, 1, 32'h2002, 0, 1);
    chk("t5_no_req_on_redirect", {31'b0, obs_rv}, 0);
    step(1, 0, 0, 0, 1);
    chk("t5_req_valid", {31'b0, obs_rv}, 1);
    chk("t5_req_addr", obs_addr, 32'h2000);
    chk("t5_no_instr", {31'b0, obs_iv}, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1);
  endtask

  task automatic rand_run(input int n, input int redir_pct);
    for (int i = 0; i < n; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) < redir_pct, $urandom,
           $urandom_range(0, 2) == 0, $urandom_range(1, 4));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    t1_stream();
    t2_stall();
    t3_ready_low();
    t4_redirect_inflight();
    t5_redirect_with_rsp();
    rand_run(400, 5);
    rand_run(100, 40);
    do_reset();
    step(1, 0, 0, 0, 2);
    chk("t6_restart_addr", obs_addr, 32'h1000);
    chk("t6_restart_valid", {31'b0, obs_rv}, 1);
    rand_run(200, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
